// File: rtl/msg_pkg.sv
// msg_pkg: shared types and default contents for the message streamer.
// Rev 1.0
`default_nettype none

package msg_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [7:0] PAD_DEFAULT = 8'h20;

    // Entry 0 sits in the least significant byte: "HELLO WORLD!" LF CR, then two pad bytes.
    localparam logic [127:0] HELLO_MSG = {8'h20, 8'h20, 8'h0D, 8'h0A, "!DLROW OLLEH"};

endpackage

`default_nettype wire

// File: rtl/msg_streamer_if.sv
// msg_streamer_if: valid/ready byte stream carrying tx_data with an end-of-message qualifier.
// Rev 1.0
`default_nettype none

interface msg_streamer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_last;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );
endinterface

`default_nettype wire

// File: rtl/msg_rom_param.sv
// msg_rom_param: combinational message lookup; any index at or beyond DEPTH returns PAD.
// Rev 1.0
`default_nettype none

import msg_pkg::*;

module msg_rom_param #(
    parameter int                      DATA_W = 8,
    parameter int                      DEPTH  = 16,
    parameter int                      ADDR_W = $clog2(DEPTH),
    parameter logic [DATA_W*DEPTH-1:0] MSG    = HELLO_MSG,
    parameter logic [DATA_W-1:0]       PAD    = PAD_DEFAULT
) (
    input  logic [ADDR_W:0]   idx,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = PAD;
        for (int i = 0; i < DEPTH; i++) begin
            if (idx == i[ADDR_W:0]) begin
                data = MSG[DATA_W*i +: DATA_W];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/msg_streamer.sv
// msg_streamer: streams a stored message over a valid/ready byte interface
// with runtime length, repeat mode, abort and a done pulse. Rev 1.0
`default_nettype none

import msg_pkg::*;

module msg_streamer #(
    parameter int                      DATA_W = 8,
    parameter int                      DEPTH  = 16,
    parameter int                      ADDR_W = $clog2(DEPTH),
    parameter logic [DATA_W*DEPTH-1:0] MSG    = HELLO_MSG,
    parameter logic [DATA_W-1:0]       PAD    = PAD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              repeat_en,
    input  logic [ADDR_W:0]   len,
    msg_streamer_if.master    tx,
    output logic              busy,
    output logic              done
);

    state_t              state, state_n;
    logic [ADDR_W:0]     idx, idx_n;
    logic [ADDR_W:0]     len_q, len_q_n;
    logic [DATA_W-1:0]   data_q, data_n;
    logic                valid_q, valid_n;
    logic                last_q, last_n;
    logic                busy_q, busy_n;
    logic                done_q, done_n;

    logic [ADDR_W:0]     idx_inc;
    logic [ADDR_W:0]     rom_addr;
    logic [DATA_W-1:0]   rom_data;
    logic                more;

    assign idx_inc = idx + 1'b1;
    assign more    = (idx_inc < len_q);

    // Idle and wrap-around both fetch entry 0; otherwise prefetch the following entry.
    always_comb begin
        rom_addr = idx_inc;
        if (state == IDLE || !more) begin
            rom_addr = '0;
        end
    end

    msg_rom_param #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .MSG    (MSG),
        .PAD    (PAD)
    ) u_rom (
        .idx  (rom_addr),
        .data (rom_data)
    );

    always_comb begin
        state_n = state;
        idx_n   = idx;
        len_q_n = len_q;
        data_n  = data_q;
        valid_n = valid_q;
        last_n  = last_q;
        busy_n  = busy_q;
        done_n  = 1'b0;

        if (abort) begin
            state_n = IDLE;
            valid_n = 1'b0;
            last_n  = 1'b0;
            busy_n  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (len != '0)) begin
                        len_q_n = len;
                        idx_n   = '0;
                        data_n  = rom_data;
                        valid_n = 1'b1;
                        last_n  = (len == {{ADDR_W{1'b0}}, 1'b1});
                        busy_n  = 1'b1;
                        state_n = SEND;
                    end
                end
                SEND: begin
                    if (valid_q && tx.tx_ready) begin
                        if (more) begin
                            idx_n  = idx_inc;
                            data_n = rom_data;
                            last_n = ((idx_inc + 1'b1) == len_q);
                        end else if (repeat_en) begin
                            idx_n  = '0;
                            data_n = rom_data;
                            last_n = (len_q == {{ADDR_W{1'b0}}, 1'b1});
                        end else begin
                            valid_n = 1'b0;
                            last_n  = 1'b0;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            len_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            len_q   <= len_q_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            last_q  <= last_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    assign tx.tx_data  = data_q;
    assign tx.tx_valid = valid_q;
    assign tx.tx_last  = last_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_msg_streamer.sv
// tb_msg_streamer: directed self-checking bench for msg_streamer with default parameters.
// Rev 1.0
`default_nettype none

module tb_msg_streamer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       repeat_en;
    logic [4:0] len;
    logic       busy;
    logic       done;

    int errors;
    int checks;
    int got;
    logic hs;

    logic [7:0]  hello [0:15];
    logic [15:0] pat;

    msg_streamer_if #(.DATA_W(8)) tx_if ();

    msg_streamer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .repeat_en (repeat_en),
        .len       (len),
        .tx        (tx_if),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int k);
        if (k < 16) return hello[k];
        return 8'h20;
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h57, 8'h4F,
                  8'h52, 8'h4C, 8'h44, 8'h21, 8'h0A, 8'h0D, 8'h20, 8'h20};
        pat = 16'b1001_0110_0011_0101;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; repeat_en = 1'b0; len = 5'd0;
        tx_if.tx_ready = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(tx_if.tx_valid), 32'd0);
        chk("rst_last",  32'(tx_if.tx_last),  32'd0);
        chk("rst_data",  32'(tx_if.tx_data),  32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        rst_n = 1'b1;
        step();

        // Full message at full throughput.
        len = 5'd14; tx_if.tx_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 14; k++) begin
            chk("t1_valid", 32'(tx_if.tx_valid), 32'd1);
            chk("t1_data",  32'(tx_if.tx_data),  32'(exp_byte(k)));
            chk("t1_last",  32'(tx_if.tx_last),  32'(k == 13));
            chk("t1_busy",  32'(busy), 32'd1);
            chk("t1_done",  32'(done), 32'd0);
            step();
        end
        chk("t1_done_pulse", 32'(done), 32'd1);
        chk("t1_valid_end",  32'(tx_if.tx_valid), 32'd0);
        chk("t1_busy_end",   32'(busy), 32'd0);
        step();
        chk("t1_done_clear", 32'(done), 32'd0);

        // Backpressure with len=5.
        len = 5'd5; tx_if.tx_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        got = 0;
        for (int c = 0; c < 64 && got < 5; c++) begin
            chk("t2_valid", 32'(tx_if.tx_valid), 32'd1);
            chk("t2_data",  32'(tx_if.tx_data),  32'(exp_byte(got)));
            chk("t2_last",  32'(tx_if.tx_last),  32'(got == 4));
            hs = tx_if.tx_ready;
            step();
            if (hs) got++;
            tx_if.tx_ready = pat[c % 16];
        end
        chk("t2_count", 32'(got), 32'd5);
        chk("t2_done",  32'(done), 32'd1);
        chk("t2_valid_end", 32'(tx_if.tx_valid), 32'd0);
        step();

        // Length beyond DEPTH reads PAD.
        len = 5'd18; tx_if.tx_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 18; k++) begin
            chk("t3_data", 32'(tx_if.tx_data), 32'(exp_byte(k)));
            chk("t3_last", 32'(tx_if.tx_last), 32'(k == 17));
            step();
        end
        chk("t3_done", 32'(done), 32'd1);
        step();

        // Repeat mode, then drop repeat_en ahead of a last byte.
        len = 5'd3; repeat_en = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("t4_valid", 32'(tx_if.tx_valid), 32'd1);
            chk("t4_data",  32'(tx_if.tx_data), 32'(exp_byte(k % 3)));
            chk("t4_last",  32'(tx_if.tx_last), 32'((k % 3) == 2));
            chk("t4_done",  32'(done), 32'd0);
            if (k == 10) repeat_en = 1'b0;
            step();
        end
        chk("t4_done_pulse", 32'(done), 32'd1);
        chk("t4_valid_end",  32'(tx_if.tx_valid), 32'd0);
        step();

        // Abort while stalled on byte 6.
        len = 5'd14; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) step();
        tx_if.tx_ready = 1'b0;
        step();
        step();
        chk("t5_hold_data",  32'(tx_if.tx_data), 32'h20);
        chk("t5_hold_valid", 32'(tx_if.tx_valid), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_valid", 32'(tx_if.tx_valid), 32'd0);
        chk("t5_last",  32'(tx_if.tx_last), 32'd0);
        chk("t5_busy",  32'(busy), 32'd0);
        chk("t5_done",  32'(done), 32'd0);
        step();
        chk("t5_done_later", 32'(done), 32'd0);

        // Restart after abort; start and len during SEND are ignored.
        len = 5'd4; tx_if.tx_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t6_data", 32'(tx_if.tx_data), 32'(exp_byte(k)));
            chk("t6_last", 32'(tx_if.tx_last), 32'(k == 3));
            if (k == 1) begin
                start = 1'b1;
                len = 5'd2;
            end
            step();
            start = 1'b0;
        end
        chk("t6_done", 32'(done), 32'd1);
        step();

        // start with len=0 is ignored.
        len = 5'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("t7_valid", 32'(tx_if.tx_valid), 32'd0);
        chk("t7_busy",  32'(busy), 32'd0);
        step();
        chk("t7_done",  32'(done), 32'd0);

        // Asynchronous reset mid-message.
        len = 5'd14; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("t8_pre_valid", 32'(tx_if.tx_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t8_valid", 32'(tx_if.tx_valid), 32'd0);
        chk("t8_last",  32'(tx_if.tx_last), 32'd0);
        chk("t8_data",  32'(tx_if.tx_data), 32'd0);
        chk("t8_busy",  32'(busy), 32'd0);
        chk("t8_done",  32'(done), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("t8_after_done", 32'(done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/msg_streamer.md
Name: msg_streamer

Overview:
Parametrised message source that streams a stored character sequence out over a valid/ready byte interface, e.g. into the UART TX path. It replaces the fixed 14-entry lookup with a configurable width, depth and contents. It adds a runtime length, single-shot or repeat mode, abort, and end-of-message signalling. It sits between control logic (button or host command) and a serial transmitter.

Parameters:
DATA_W, 8, bits per entry.
DEPTH, 16, number of ROM entries (>=2).
ADDR_W, $clog2(DEPTH), entry index width (derived; do not override).
MSG, DATA_W*DEPTH bits, ROM contents. Entry i = MSG[DATA_W*i +: DATA_W]. Default: entry 0..13 = "HELLO WORLD!" LF CR, entries 14..15 = PAD.
PAD, 8'h20, value returned for any index >= DEPTH.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begin message when idle
abort  in  1  terminate current message
repeat_en  in  1  1 = restart from entry 0 after last byte
len  in  ADDR_W+1  bytes per message, sampled on accepted start
tx_data  out  DATA_W  current byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  downstream accepts byte when tx_valid & tx_ready
tx_last  out  1  qualifies final byte of message (valid with tx_valid)
busy  out  1  high from accepted start until return to IDLE
done  out  1  one-cycle pulse after final byte of a non-repeating message

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, idx=0, len_q=0. tx_data=0, tx_valid=0, tx_last=0, busy=0, done=0. Applies mid-message with no partial completion and no done pulse.
- States: IDLE, SEND.
- IDLE: accepted start = start & ~abort & (len!=0). On the accepting edge:
  - len_q<=len, idx<=0.
  - tx_data<=rom(0), tx_valid<=1, tx_last<=(len==1), busy<=1, state->SEND.
  - Latency: start sampled at edge N gives byte 0 valid after edge N.
- start with len==0 is ignored: it stays IDLE with no done pulse.
- SEND: tx_data and tx_last are held stable while tx_valid & ~tx_ready. On a handshake:
  - Not last (idx+1 < len_q): idx<=idx+1, tx_data<=rom(idx+1), tx_last<=(idx+2==len_q), tx_valid stays 1. This gives full throughput of 1 byte/cycle with tx_ready held high.
  - Last byte with repeat_en=1 (sampled at that handshake): idx<=0, tx_data<=rom(0), tx_last<=(len_q==1), stays SEND, no done pulse.
  - Last byte with repeat_en=0: tx_valid<=0, tx_last<=0, busy<=0, done<=1 for one cycle, state->IDLE.
- abort (any state, synchronous): next edge forces IDLE with tx_valid=0, tx_last=0, busy=0, and no done pulse. abort overrides a handshake and start in the same cycle.
- start while in SEND is ignored. len changes after acceptance have no effect.
- rom(i): combinational lookup. Returns MSG entry i for i < DEPTH and PAD for i >= DEPTH. len may exceed DEPTH, in which case the tail is PAD.
- tx_data holds its last value when tx_valid=0. Consumers must not rely on it.
- Index arithmetic is done in ADDR_W+1 bits with no wrap inside a message.
- done is registered and is high only on the cycle after the final handshake.

Decomposition:
- Package msg_pkg holds:
  - state enum {IDLE, SEND}
  - default PAD constant 8'h20
  - default HELLO message constant
- Sub-module msg_rom_param (DATA_W, DEPTH, MSG, PAD): purely combinational index -> data with out-of-range padding.
- msg_streamer holds all sequential logic.

Test Plan:
- Default params, len=14, repeat_en=0, tx_ready=1, start pulse -> bytes 48 45 4C 4C 4F 20 57 4F 52 4C 44 21 0A 0D on 14 consecutive cycles starting the cycle after start. tx_last only on 0D. done one cycle later. busy high for exactly 14 cycles.
- tx_ready toggled pseudo-randomly, len=5 -> data and tx_last stable during stalls. Exactly 48 45 4C 4C 4F delivered with no duplicates or drops.
- len=18 -> entries 14..17 read 20 (PAD). tx_last on the 18th byte.
- repeat_en=1, len=3, tx_ready=1 -> 48 45 4C 48 45 4C ... with tx_last every third byte and no done. Dropping repeat_en before a last byte ends the stream after that byte with done=1.
- abort during byte 6 with tx_ready=0 -> next cycle tx_valid=0, busy=0, no done. A new start then begins again at 48.
- rst_n asserted mid-message -> all outputs 0 immediately. start with len=0 is ignored. start during SEND is ignored.
